// File: rtl/carry_select_subtractor_pipe16_if.sv
// Valid/ready operand and result channel for the pipelined carry-select subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface carry_select_subtractor_pipe16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             Bout;
  logic             ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, diff, Bout, ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, diff, Bout, ovf
  );
endinterface

// File: rtl/carry_select_subtractor_pipe16.sv
// Pipelined subtractor D = A - B - Bin, one carry-select slice resolved per stage.
// Subtraction is done as A + ~B + ~Bin, so the inter-stage carry is an inverted borrow.
module carry_select_subtractor_pipe16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input logic                            clk,
  input logic                            rst,
  carry_select_subtractor_pipe16_if.slave io
);
  // Requires WIDTH to be a multiple of SLICE and at least two stages.
  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;

  // Both carry-in candidates are formed up front; the registered carry only drives the mux.
  function automatic logic [SLICE:0] csel(input logic [SLICE-1:0] a,
                                          input logic [SLICE-1:0] nb,
                                          input logic             cin);
    logic [SLICE:0] sum0;
    logic [SLICE:0] sum1;
    sum0 = {1'b0, a} + {1'b0, nb};
    sum1 = {1'b0, a} + {1'b0, nb} + {{SLICE{1'b0}}, 1'b1};
    return cin ? sum1 : sum0;
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES:0]   ready;

  always_comb begin
    ready[STAGES] = io.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready[i] = ~v[i] | ready[i+1];
    end
  end

  assign io.in_ready  = ready[0];
  assign io.out_valid = v[LAST];

  // Stages 0..LAST-1 carry the finished low diff bits plus the still-unprocessed upper operands.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * SLICE;
    localparam int unsigned DW = (k + 1) * SLICE;

    logic [IW-1:0]       src_a;
    logic [IW-1:0]       src_b;
    logic                src_cin;
    logic                src_v;
    logic [SLICE:0]      sum;
    logic [DW-1:0]       nxt_diff;
    logic [IW-SLICE-1:0] a_q;
    logic [IW-SLICE-1:0] b_q;
    logic [DW-1:0]       diff_q;
    logic                cy_q;
    logic                v_q;

    if (k == 0) begin : g_head
      assign src_a    = io.A;
      assign src_b    = io.B;
      assign src_cin  = ~io.Bin;
      assign src_v    = io.in_valid;
      assign nxt_diff = sum[SLICE-1:0];
    end else begin : g_body
      assign src_a    = g_stage[k-1].a_q;
      assign src_b    = g_stage[k-1].b_q;
      assign src_cin  = g_stage[k-1].cy_q;
      assign src_v    = g_stage[k-1].v_q;
      assign nxt_diff = {sum[SLICE-1:0], g_stage[k-1].diff_q};
    end

    assign sum  = csel(src_a[SLICE-1:0], ~src_b[SLICE-1:0], src_cin);
    assign v[k] = v_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= 1'b0;
        cy_q   <= 1'b0;
        a_q    <= '0;
        b_q    <= '0;
        diff_q <= '0;
      end else if (ready[k]) begin
        v_q    <= src_v;
        cy_q   <= sum[SLICE];
        a_q    <= src_a[IW-1:SLICE];
        b_q    <= src_b[IW-1:SLICE];
        diff_q <= nxt_diff;
      end
    end
  end

  // Final stage holds the MSB slice, so borrow-out and signed overflow resolve here.
  logic [SLICE:0]   last_sum;
  logic             last_amsb;
  logic             last_bmsb;
  logic             last_ovf;
  logic             last_v_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  assign last_sum  = csel(g_stage[LAST-1].a_q, ~g_stage[LAST-1].b_q, g_stage[LAST-1].cy_q);
  assign last_amsb = g_stage[LAST-1].a_q[SLICE-1];
  assign last_bmsb = g_stage[LAST-1].b_q[SLICE-1];
  assign last_ovf  = (last_amsb != last_bmsb) && (last_sum[SLICE-1] != last_amsb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_v_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ready[LAST]) begin
      last_v_q <= g_stage[LAST-1].v_q;
      diff_q   <= {last_sum[SLICE-1:0], g_stage[LAST-1].diff_q};
      bout_q   <= ~last_sum[SLICE];
      ovf_q    <= last_ovf;
    end
  end

  assign v[LAST] = last_v_q;
  assign io.diff = diff_q;
  assign io.Bout = bout_q;
  assign io.ovf  = ovf_q;
endmodule
